// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory port arbiter.
package imem_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 13;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned MAX_WAIT_DEF = 4;

    // Port owner: the fetch stage or the loader/debug port.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating loader wait counter; expired_o flags cnt == MAX_WAIT-1.
module arb_wait_counter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CNT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);
    localparam logic RST_EXPIRED = (MAX_WAIT == 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             expired_q;

    // Next count: clear wins, otherwise increment up to saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register; expired is registered from the next count so it tracks cnt_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            expired_q <= RST_EXPIRED;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == CNT_MAX);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter between fetch and the loader/debug port.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_stall_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic              ld_lock_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic if_issue;
    logic ld_rd_issue;
    logic wait_inc;
    logic wait_clr;
    logic wait_expired;
    logic if_rvalid_q;
    logic ld_rvalid_q;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (wait_inc),
        .clr_i     (wait_clr),
        .expired_o (wait_expired)
    );

    // Next-state, memory mux and handshake decode.
    always_comb begin
        state_d     = state_q;
        mem_addr_o  = if_addr_i;
        mem_we_o    = 1'b0;
        mem_wdata_o = ld_wdata_i;
        if_stall_o  = 1'b0;
        ld_gnt_o    = 1'b0;
        if_issue    = 1'b0;
        ld_rd_issue = 1'b0;
        wait_inc    = 1'b0;
        wait_clr    = 1'b1;

        if (rst_i) begin
            if_stall_o = 1'b1;
            state_d    = OWN_IF;
        end else begin
            unique case (state_q)
                OWN_IF: begin
                    if_issue = if_req_i;
                    wait_inc = ld_req_i & if_req_i;
                    wait_clr = ~wait_inc;
                    if (ld_req_i && (!if_req_i || wait_expired)) begin
                        state_d  = OWN_LD;
                        wait_clr = 1'b1;
                    end
                end
                OWN_LD: begin
                    mem_addr_o  = ld_addr_i;
                    mem_we_o    = ld_req_i & ld_we_i;
                    ld_gnt_o    = ld_req_i;
                    ld_rd_issue = ld_req_i & ~ld_we_i;
                    if_stall_o  = 1'b1;
                    state_d     = (ld_req_i && ld_lock_i) ? OWN_LD : OWN_IF;
                end
                default: state_d = OWN_IF;
            endcase
        end
    end

    // Owner state and one-cycle read-response valids; a flush kills the fetch response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= OWN_IF;
            if_rvalid_q <= 1'b0;
            ld_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_rvalid_q <= if_issue & ~if_flush_i;
            ld_rvalid_q <= ld_rd_issue;
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign ld_rvalid_o = ld_rvalid_q;
    assign if_rdata_o  = mem_rdata_i;
    assign ld_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle-latency memory.
module tb_imem_port_arbiter;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_flush_i = 1'b0;
    logic              if_stall_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              ld_req_i = 1'b0;
    logic              ld_we_i = 1'b0;
    logic              ld_lock_i = 1'b0;
    logic [ADDR_W-1:0] ld_addr_i = '0;
    logic [DATA_W-1:0] ld_wdata_i = '0;
    logic              ld_gnt_o;
    logic              ld_rvalid_o;
    logic [DATA_W-1:0] ld_rdata_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_stall_o  (if_stall_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ld_req_i    (ld_req_i),
        .ld_we_i     (ld_we_i),
        .ld_lock_i   (ld_lock_i),
        .ld_addr_i   (ld_addr_i),
        .ld_wdata_i  (ld_wdata_i),
        .ld_gnt_o    (ld_gnt_o),
        .ld_rvalid_o (ld_rvalid_o),
        .ld_rdata_o  (ld_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Synchronous RAM: read-before-write, data valid one cycle after address.
    always @(posedge clk) begin
        mem_rdata_i <= mem[mem_addr_o];
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before checks.
    task automatic cyc(input logic rst, input logic ifr, input logic [12:0] ifa, input logic fl,
                       input logic ldr, input logic we, input logic lk,
                       input logic [12:0] lda, input logic [31:0] wd);
        @(negedge clk);
        rst_i      = rst;
        if_req_i   = ifr;
        if_addr_i  = ifa;
        if_flush_i = fl;
        ld_req_i   = ldr;
        ld_we_i    = we;
        ld_lock_i  = lk;
        ld_addr_i  = lda;
        ld_wdata_i = wd;
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hC000_0000 | 32'(i);

        // Reset held two cycles with fetch requesting.
        cyc(1, 1, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("rst1_stall", 32'(if_stall_o), 32'd1);
        check("rst1_we", 32'(mem_we_o), 32'd0);
        cyc(1, 1, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("rst2_stall", 32'(if_stall_o), 32'd1);
        check("rst2_gnt", 32'(ld_gnt_o), 32'd0);
        check("rst2_ifrv", 32'(if_rvalid_o), 32'd0);
        check("rst2_ldrv", 32'(ld_rvalid_o), 32'd0);
        cyc(0, 1, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("post_rst_addr", 32'(mem_addr_o), 32'h000);
        check("post_rst_stall", 32'(if_stall_o), 32'd0);
        check("post_rst_ifrv", 32'(if_rvalid_o), 32'd0);
        cyc(0, 0, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("first_ifrv", 32'(if_rvalid_o), 32'd1);
        check("first_ifrdata", if_rdata_o, 32'hC000_0000);

        // Starvation bound: loader read of 0x020 against continuous fetch.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 13'(13'h100 + i), 0, 1, 0, 0, 13'h020, 32'h0);
            check("starve_stall", 32'(if_stall_o), 32'd0);
            check("starve_gnt", 32'(ld_gnt_o), 32'd0);
            check("starve_addr", 32'(mem_addr_o), 32'h100 + 32'(i));
            check("starve_ifrv", 32'(if_rvalid_o), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) check("starve_ifrdata", if_rdata_o, 32'hC000_00FF + 32'(i));
        end
        cyc(0, 1, 13'h104, 0, 1, 0, 0, 13'h020, 32'h0);
        check("starve_c4_gnt", 32'(ld_gnt_o), 32'd1);
        check("starve_c4_stall", 32'(if_stall_o), 32'd1);
        check("starve_c4_addr", 32'(mem_addr_o), 32'h020);
        check("starve_c4_we", 32'(mem_we_o), 32'd0);
        check("starve_c4_ifrdata", if_rdata_o, 32'hC000_0103);
        cyc(0, 1, 13'h104, 0, 0, 0, 0, 13'h020, 32'h0);
        check("starve_c5_ldrv", 32'(ld_rvalid_o), 32'd1);
        check("starve_c5_ldrdata", ld_rdata_o, 32'hC000_0020);
        check("starve_c5_stall", 32'(if_stall_o), 32'd0);
        check("starve_c5_addr", 32'(mem_addr_o), 32'h104);
        check("starve_c5_ifrv", 32'(if_rvalid_o), 32'd0);
        cyc(0, 0, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("starve_c6_ifrv", 32'(if_rvalid_o), 32'd1);
        check("starve_c6_ifrdata", if_rdata_o, 32'hC000_0104);
        check("starve_c6_ldrv", 32'(ld_rvalid_o), 32'd0);

        // Idle fetch: loader granted one cycle after request.
        cyc(0, 0, 13'h000, 0, 1, 0, 0, 13'h030, 32'h0);
        check("idle_c0_gnt", 32'(ld_gnt_o), 32'd0);
        check("idle_c0_stall", 32'(if_stall_o), 32'd0);
        cyc(0, 0, 13'h000, 0, 1, 0, 0, 13'h030, 32'h0);
        check("idle_c1_gnt", 32'(ld_gnt_o), 32'd1);
        check("idle_c1_stall", 32'(if_stall_o), 32'd1);
        check("idle_c1_addr", 32'(mem_addr_o), 32'h030);
        cyc(0, 0, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("idle_c2_ldrv", 32'(ld_rvalid_o), 32'd1);
        check("idle_c2_ldrdata", ld_rdata_o, 32'hC000_0030);
        check("idle_c2_stall", 32'(if_stall_o), 32'd0);

        // Locked write burst to 0x010..0x012.
        cyc(0, 0, 13'h000, 0, 1, 1, 1, 13'h010, 32'hA0);
        check("burst_c0_gnt", 32'(ld_gnt_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 13'h000, 0, 1, 1, (i < 2) ? 1'b1 : 1'b0, 13'(13'h010 + i), 32'hA0 + 32'(i));
            check("burst_gnt", 32'(ld_gnt_o), 32'd1);
            check("burst_we", 32'(mem_we_o), 32'd1);
            check("burst_stall", 32'(if_stall_o), 32'd1);
            check("burst_addr", 32'(mem_addr_o), 32'h010 + 32'(i));
            check("burst_wdata", mem_wdata_o, 32'hA0 + 32'(i));
        end
        cyc(0, 1, 13'h200, 0, 0, 0, 0, 13'h000, 32'h0);
        check("burst_end_stall", 32'(if_stall_o), 32'd0);
        check("burst_end_addr", 32'(mem_addr_o), 32'h200);
        check("burst_end_we", 32'(mem_we_o), 32'd0);
        check("burst_end_ldrv", 32'(ld_rvalid_o), 32'd0);

        // Read back the burst with a locked read burst.
        cyc(0, 0, 13'h000, 0, 1, 0, 1, 13'h010, 32'h0);
        check("rb_ifrv", 32'(if_rvalid_o), 32'd1);
        check("rb_ifrdata", if_rdata_o, 32'hC000_0200);
        cyc(0, 0, 13'h000, 0, 1, 0, 1, 13'h010, 32'h0);
        check("rb_c1_gnt", 32'(ld_gnt_o), 32'd1);
        cyc(0, 0, 13'h000, 0, 1, 0, 1, 13'h011, 32'h0);
        check("rb_w0_rv", 32'(ld_rvalid_o), 32'd1);
        check("rb_w0_data", ld_rdata_o, 32'h0000_00A0);
        cyc(0, 0, 13'h000, 0, 1, 0, 0, 13'h012, 32'h0);
        check("rb_w1_data", ld_rdata_o, 32'h0000_00A1);
        cyc(0, 0, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("rb_w2_rv", 32'(ld_rvalid_o), 32'd1);
        check("rb_w2_data", ld_rdata_o, 32'h0000_00A2);
        check("rb_end_stall", 32'(if_stall_o), 32'd0);

        // Flush kills only the response of the flushed issue.
        cyc(0, 1, 13'h040, 1, 0, 0, 0, 13'h000, 32'h0);
        check("flush_n_stall", 32'(if_stall_o), 32'd0);
        cyc(0, 1, 13'h041, 0, 0, 0, 0, 13'h000, 32'h0);
        check("flush_n1_ifrv", 32'(if_rvalid_o), 32'd0);
        cyc(0, 0, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("flush_n2_ifrv", 32'(if_rvalid_o), 32'd1);
        check("flush_n2_ifrdata", if_rdata_o, 32'hC000_0041);

        // Reset during burst word 2: no write, burst abandoned.
        cyc(0, 0, 13'h000, 0, 1, 1, 1, 13'h050, 32'hB0);
        cyc(0, 0, 13'h000, 0, 1, 1, 1, 13'h050, 32'hB0);
        check("rstb_w0_we", 32'(mem_we_o), 32'd1);
        cyc(0, 0, 13'h000, 0, 1, 1, 1, 13'h051, 32'hB1);
        check("rstb_w1_we", 32'(mem_we_o), 32'd1);
        cyc(1, 0, 13'h000, 0, 1, 1, 1, 13'h052, 32'hB2);
        check("rstb_w2_we", 32'(mem_we_o), 32'd0);
        check("rstb_w2_gnt", 32'(ld_gnt_o), 32'd0);
        check("rstb_w2_stall", 32'(if_stall_o), 32'd1);
        cyc(0, 1, 13'h060, 0, 0, 0, 0, 13'h000, 32'h0);
        check("rstb_after_stall", 32'(if_stall_o), 32'd0);
        check("rstb_after_addr", 32'(mem_addr_o), 32'h060);
        check("rstb_after_ldrv", 32'(ld_rvalid_o), 32'd0);
        cyc(0, 0, 13'h000, 0, 1, 0, 0, 13'h052, 32'h0);
        check("rstb_rd_ifrv", 32'(if_rvalid_o), 32'd1);
        cyc(0, 0, 13'h000, 0, 1, 0, 0, 13'h052, 32'h0);
        check("rstb_rd_gnt", 32'(ld_gnt_o), 32'd1);
        cyc(0, 0, 13'h000, 0, 0, 0, 0, 13'h000, 32'h0);
        check("rstb_w2_unchanged", ld_rdata_o, 32'hC000_0052);
        check("rstb_w1_written", mem[13'h051], 32'h0000_00B1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates the single-port instruction memory between the fetch stage and a program-loader/debug port. It issues exactly one memory access per cycle, drives the fetch stall while the loader owns the port, and bounds loader starvation with a wait counter. It sits between the PC/fetch logic and the instruction memory, beside the branch-redirect path.

## Interface
Parameters:
- ADDR_W, 13, instruction-memory word-address width (matches PC bits [12:0])
- DATA_W, 32, instruction word width
- MAX_WAIT, 4, maximum number of cycles a loader request can wait while fetch is busy (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- if_req_i  in  1  fetch wants a read this cycle
- if_addr_i  in  ADDR_W  fetch address (PC)
- if_flush_i  in  1  branch redirect (is_taken_E); kills the in-flight fetch response
- if_stall_o  out  1  fetch address not accepted this cycle; PC and IF/ID must hold
- if_rvalid_o  out  1  if_rdata_o valid
- if_rdata_o  out  DATA_W  fetched instruction
- ld_req_i  in  1  loader access request
- ld_we_i  in  1  1 = write, 0 = read
- ld_lock_i  in  1  keep ownership for the next loader access (burst)
- ld_addr_i  in  ADDR_W  loader address
- ld_wdata_i  in  DATA_W  loader write data
- ld_gnt_o  out  1  loader access performed this cycle
- ld_rvalid_o  out  1  ld_rdata_o valid
- ld_rdata_o  out  DATA_W  loader read data
- mem_addr_o  out  ADDR_W  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid one cycle after the address

## Operation
- Two states: OWN_IF and OWN_LD. Reset state: OWN_IF.
- OWN_IF:
  - mem_addr_o = if_addr_i; mem_we_o = 0; if_stall_o = 0; ld_gnt_o = 0.
  - wait_cnt increments, saturating at MAX_WAIT−1, each cycle that ld_req_i and if_req_i are both high. It clears otherwise and on entry to OWN_LD.
  - Go to OWN_LD when ld_req_i and either (not if_req_i) or (wait_cnt == MAX_WAIT−1). The fetch access of the deciding cycle is still performed.
- OWN_LD:
  - mem_addr_o = ld_addr_i; mem_we_o = ld_req_i & ld_we_i; mem_wdata_o = ld_wdata_i.
  - ld_gnt_o = ld_req_i; if_stall_o = 1.
  - Stay in OWN_LD if ld_req_i & ld_lock_i; otherwise return to OWN_IF. A burst has no length cap.
  - If ld_req_i drops while in OWN_LD, the cycle is idle (no write) and the block returns to OWN_IF.
- ld_lock_i is ignored in OWN_IF.
- Responses:
  - if_rvalid_o(N+1) = fetch read issued at N (OWN_IF & if_req_i & ~rst_i) & ~if_flush_i(N).
  - ld_rvalid_o(N+1) = loader read granted at N.
  - if_rdata_o and ld_rdata_o both carry mem_rdata_i (passthrough).
- Simultaneous if_flush_i and loader switch: the switch proceeds and the flushed response is still killed.

## Timing
- During rst_i: if_stall_o = 1; mem_we_o = 0; ld_gnt_o = 0; next state OWN_IF; wait_cnt = 0; if_rvalid_o and ld_rvalid_o are 0 the following cycle.
- Reset asserted mid-burst: no write is issued in the reset cycle, and the burst is abandoned.
- Read latency is 1 cycle for both requesters.
- Loader grant latency:
  - 1 cycle if fetch is idle.
  - At most MAX_WAIT cycles from ld_req_i rise while fetch requests continuously.
- Fetch penalty = number of OWN_LD cycles (if_stall_o high each of them).

## Structure
- Package imem_arb_pkg:
  - state enum {OWN_IF, OWN_LD}
  - default ADDR_W/DATA_W constants
- Sub-module arb_wait_counter: saturating counter with inc, clr and sync reset; outputs expired = (cnt == MAX_WAIT−1).
- Top level holds the FSM, the output muxes and the two response-valid flops.

## Test plan
- Reset: hold rst_i 2 cycles with if_req_i = 1. Required: if_stall_o = 1, mem_we_o = 0. After release, if_addr_i = 0x000 gives mem_addr_o = 0x000, then if_rvalid_o = 1 next cycle with if_rdata_o = mem contents.
- Starvation bound: MAX_WAIT = 4, if_req_i always 1, ld_req_i rises at cycle 0 (read of 0x020). Required: fetch served cycles 0–3, ld_gnt_o = 1 at cycle 4 with if_stall_o = 1, ld_rvalid_o at cycle 5, back to OWN_IF at cycle 5.
- Idle fetch: if_req_i = 0, ld_req_i = 1 at cycle 0. Required: ld_gnt_o at cycle 1.
- Locked burst: writes 0xA0,0xA1,0xA2 to 0x010–0x012 with ld_lock_i high for the first two. Required: three consecutive gnt cycles with mem_we_o = 1, if_stall_o = 1 throughout, fetch resumes the next cycle, and read-back returns the written words.
- Flush: fetch issue at N with if_flush_i = 1 at N. Required: if_rvalid_o = 0 at N+1; an unflushed issue at N+1 gives if_rvalid_o = 1 at N+2.
- Reset mid-burst: rst_i at burst word 2. Required: mem_we_o = 0 that cycle, word 2 unchanged in memory, state OWN_IF after reset.
